approx_wallace_mac: RTL and testbench
=====================================

APPROX_WALLACE_MAC -- requirements
Module: approx_wallace_mac

Interface
REQ-001 SHALL have parameter WIDTH, default 8: unsigned operand width, legal range 4..16.
REQ-002 SHALL have parameter APPROX_COLS, default 4: number of low product columns reduced approximately, legal range 0..2*WIDTH-1.
REQ-003 SHALL have parameter ACC_WIDTH, default 2*WIDTH+8: accumulator width, minimum 2*WIDTH.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have ports in_valid (input, 1) and in_ready (output, 1): input handshake.
REQ-007 SHALL have ports a and b, both input, WIDTH bits: unsigned operands.
REQ-008 SHALL have port acc_clr, input, 1 bit: qualified by the input beat; that beat's accumulation starts from zero.
REQ-009 SHALL have ports out_valid (output, 1) and out_ready (input, 1): output handshake.
REQ-010 SHALL have port acc, output, ACC_WIDTH bits: running accumulated value.
REQ-011 SHALL have port ovf, output, 1 bit: sticky accumulator overflow flag.

Function
REQ-012 SHALL compute product P from the WIDTH*WIDTH partial-product bits a[i]&b[j], where column c is i+j.
REQ-013 SHALL make each bit c < APPROX_COLS of P the OR of all partial-product bits in column c, with no carry out of that column.
REQ-014 SHALL compute columns c >= APPROX_COLS by exact Wallace-tree reduction of their bits only, placed at weight 2^c.
REQ-015 SHALL produce an exact product when APPROX_COLS = 0.
REQ-016 SHALL accept an input beat on a clk edge where in_valid and in_ready are both 1.
REQ-017 SHALL form a two-stage pipeline: stage 1 registers P with acc_clr; stage 2 registers acc = (clr ? 0 : acc) + P.
REQ-018 SHALL assert out_valid two cycles after acceptance, with no bubbles under continuous flow.
REQ-019 SHALL produce exactly one output beat per accepted input beat, in order.
REQ-020 SHALL stall when out_valid=1 and out_ready=0: in_ready=0, both stages hold, and acc stays stable.
REQ-021 SHALL otherwise drive in_ready=1, so that in_ready has no combinational dependence on in_valid.
REQ-022 SHALL let an output transfer and a new input acceptance occur in the same cycle.
REQ-023 SHALL add into the accumulator only when a stage-1 beat advances into stage 2.
REQ-024 SHALL hold the accumulator value across idle cycles.
REQ-025 SHALL, when the acc_clr beat reaches stage 2, make acc equal that beat's P and clear ovf.
REQ-026 SHALL set ovf when an addition's true sum exceeds 2^ACC_WIDTH-1; ovf holds until rst or an acc_clr beat.

Reset
REQ-027 SHALL, while rst=1 on a clk edge, clear both stage valid bits, acc, and ovf to 0.
REQ-028 SHALL drive out_valid=0 and in_ready=1 in the cycle after reset.
REQ-029 SHALL discard in-flight beats when rst asserts mid-operation, and SHALL NOT accept a beat on a cycle where rst=1.

Configuration
REQ-030 SHALL, with macro APPROX_WALLACE_MAC_ACC_SAT_EN defined, clamp the accumulator to 2^ACC_WIDTH-1 on overflow, and further additions keep it there.
REQ-031 SHALL, with APPROX_WALLACE_MAC_ACC_SAT_EN undefined, wrap the accumulator modulo 2^ACC_WIDTH; ovf behaviour is identical in both builds.

Verification
REQ-032 SHALL cover: WIDTH=8, APPROX_COLS=4, a=15, b=15, acc_clr=1 -> out_valid on 2nd cycle, acc=191 (exact 225).
REQ-033 SHALL cover: WIDTH=8, APPROX_COLS=4, beats (255,1,clr) then (3,5) -> acc=255, then acc=270 (3*5 column OR gives 15).
REQ-034 SHALL cover: APPROX_COLS=0, 100 random back-to-back beats, out_ready=1 -> acc matches the exact running sum every beat, no bubbles.
REQ-035 SHALL cover: out_ready=0 for 5 cycles with out_valid=1 -> in_ready=0, acc unchanged; after release, all beats emerge in order with none lost or duplicated.
REQ-036 SHALL cover: ACC_WIDTH=16, APPROX_COLS=0, (255,255,clr) then (255,255) -> ovf=1 and acc=65535 with macro, or acc=64514 without.
REQ-037 SHALL cover: rst pulsed with both stages full -> next cycle out_valid=0, acc=0, ovf=0, in_ready=1.

Source files
------------

// File: rtl/approx_wallace_mac.sv
// Approximate-product MAC: low APPROX_COLS columns OR-reduced, the rest exact Wallace CSA tree; optional saturation via APPROX_WALLACE_MAC_ACC_SAT_EN.
// Latency: 2 cycles from input acceptance to out_valid, full throughput under continuous flow.
// Backpressure: out_valid && !out_ready freezes both stages and drops in_ready; otherwise in_ready is 1.
module approx_wallace_mac #(
    parameter int WIDTH       = 8,
    parameter int APPROX_COLS = 4,
    parameter int ACC_WIDTH   = 2*WIDTH+8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 acc_clr,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] acc,
    output logic                 ovf
);
    localparam int PW  = 2*WIDTH;
    localparam int IW  = $clog2(WIDTH);
    localparam int PIW = $clog2(PW);
    localparam logic [PW-1:0] HI_MASK = {PW{1'b1}} << APPROX_COLS;

    // OR of each approximate column; no carry leaves these columns.
    function automatic logic [PW-1:0] f_lo(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        logic [PW-1:0] lo;
        lo = '0;
        for (int i = 0; i < WIDTH; i++) begin
            for (int j = 0; j < WIDTH; j++) begin
                if (i + j < APPROX_COLS) begin
                    lo[PIW'(i + j)] = lo[PIW'(i + j)] | (x[i] & y[j]);
                end
            end
        end
        return lo;
    endfunction

    // Exact columns: rows of partial products with approximate columns masked,
    // reduced layer by layer with 3:2 compressors down to two rows.
    function automatic logic [PW-1:0] f_hi(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        logic [PW-1:0] rows [WIDTH];
        logic [PW-1:0] nxt  [WIDTH];
        int n;
        int m;
        for (int i = 0; i < WIDTH; i++) begin
            rows[i] = x[i] ? ((PW'(y) << i) & HI_MASK) : '0;
        end
        n = WIDTH;
        for (int l = 0; l < WIDTH; l++) begin
            if (n > 2) begin
                m = 0;
                for (int k = 0; k < WIDTH; k++) begin
                    nxt[k] = '0;
                end
                for (int k = 0; k + 2 < WIDTH; k += 3) begin
                    if (k + 2 < n) begin
                        nxt[IW'(m)]     = rows[k] ^ rows[k+1] ^ rows[k+2];
                        nxt[IW'(m + 1)] = ((rows[k] & rows[k+1]) | (rows[k] & rows[k+2])
                                          | (rows[k+1] & rows[k+2])) << 1;
                        m = m + 2;
                    end
                end
                for (int k = 0; k < WIDTH; k++) begin
                    if (k >= 3*(n/3) && k < n) begin
                        nxt[IW'(m)] = rows[k];
                        m = m + 1;
                    end
                end
                rows = nxt;
                n    = m;
            end
        end
        return rows[0] + rows[1];
    endfunction

    logic                 w_stall;
    logic [PW-1:0]        w_p;
    logic [ACC_WIDTH-1:0] w_base;
    logic [ACC_WIDTH:0]   w_sum;
    logic                 w_carry;
    logic [ACC_WIDTH-1:0] w_acc_nxt;
    logic                 w_ovf_nxt;

    logic                 r_s1_vld;
    logic [PW-1:0]        r_s1_p;
    logic                 r_s1_clr;
    logic                 r_s2_vld;
    logic [ACC_WIDTH-1:0] r_acc;
    logic                 r_ovf;

    assign w_stall  = r_s2_vld & ~out_ready;
    assign in_ready = ~w_stall;
    assign w_p      = f_hi(a, b) | f_lo(a, b);

    assign w_base    = r_s1_clr ? '0 : r_acc;
    assign w_sum     = {1'b0, w_base} + (ACC_WIDTH+1)'(r_s1_p);
    assign w_carry   = w_sum[ACC_WIDTH];
    assign w_ovf_nxt = (~r_s1_clr & r_ovf) | w_carry;
`ifdef APPROX_WALLACE_MAC_ACC_SAT_EN
    assign w_acc_nxt = w_carry ? {ACC_WIDTH{1'b1}} : w_sum[ACC_WIDTH-1:0];
`else
    assign w_acc_nxt = w_sum[ACC_WIDTH-1:0];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_vld <= 1'b0;
            r_s2_vld <= 1'b0;
            r_acc    <= '0;
            r_ovf    <= 1'b0;
        end else if (!w_stall) begin
            r_s1_vld <= in_valid;
            if (in_valid) begin
                r_s1_p   <= w_p;
                r_s1_clr <= acc_clr;
            end
            r_s2_vld <= r_s1_vld;
            // Accumulate only when a real beat moves into stage 2.
            if (r_s1_vld) begin
                r_acc <= w_acc_nxt;
                r_ovf <= w_ovf_nxt;
            end
        end
    end

    assign out_valid = r_s2_vld;
    assign acc       = r_acc;
    assign ovf       = r_ovf;
endmodule

// File: tb/tb_approx_wallace_mac.sv
module tb_approx_wallace_mac;
    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       acc_clr;
    logic       out_ready;
    logic [7:0] a;
    logic [7:0] b;

    logic        rdy0, ov0, of0;
    logic [23:0] acc0;
    logic        rdy1, ov1, of1;
    logic [15:0] acc1;

    always #5 clk = ~clk;

    approx_wallace_mac #(.WIDTH(8), .APPROX_COLS(4)) u0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0), .a(a), .b(b),
        .acc_clr(acc_clr), .out_valid(ov0), .out_ready(out_ready), .acc(acc0), .ovf(of0));

    approx_wallace_mac #(.WIDTH(8), .APPROX_COLS(0), .ACC_WIDTH(16)) u1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .a(a), .b(b),
        .acc_clr(acc_clr), .out_valid(ov1), .out_ready(out_ready), .acc(acc1), .ovf(of1));

    typedef struct {
        longint acc;
        bit     ovf;
        int     cyc;
        bit     ff;
    } exp_t;

    exp_t   q0[$];
    exp_t   q1[$];
    int     errors = 0;
    int     checks = 0;
    int     cyc = 0;
    bit     free_flow = 1'b1;
    bit     rand_ordy = 1'b0;
    int     hold_low = 0;
    longint m_acc [2];
    bit     m_ovf [2];
    int     m_ac  [2] = '{4, 0};
    int     m_aw  [2] = '{24, 16};

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Column-count view of the product: count the set partial-product bits per column.
    function automatic longint approx_p(input int ac, input logic [7:0] x, input logic [7:0] y);
        longint p = 0;
        for (int c = 0; c < 15; c++) begin
            int n = 0;
            for (int i = 0; i < 8; i++)
                for (int j = 0; j < 8; j++)
                    if (i + j == c && x[i] && y[j]) n++;
            if (c < ac) p += (n > 0) ? (longint'(1) << c) : 0;
            else        p += longint'(n) << c;
        end
        return p;
    endfunction

    task automatic model_beat(input logic [7:0] x, input logic [7:0] y, input bit clr);
        for (int d = 0; d < 2; d++) begin
            longint mx, sum;
            bit     carry;
            exp_t   e;
            mx    = (longint'(1) << m_aw[d]) - 1;
            sum   = (clr ? 0 : m_acc[d]) + approx_p(m_ac[d], x, y);
            carry = sum > mx;
            m_ovf[d] = (clr ? 1'b0 : m_ovf[d]) | carry;
`ifdef APPROX_WALLACE_MAC_ACC_SAT_EN
            m_acc[d] = carry ? mx : sum;
`else
            m_acc[d] = sum & mx;
`endif
            e.acc = m_acc[d];
            e.ovf = m_ovf[d];
            e.cyc = cyc;
            e.ff  = free_flow;
            if (d == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
    endtask

    task automatic cycle_drive(input bit v, input logic [7:0] x, input logic [7:0] y,
                               input bit clr, output bit got);
        @(posedge clk);
        #2;
        in_valid = v;
        a        = x;
        b        = y;
        acc_clr  = clr;
        if (hold_low > 0) begin
            out_ready = 1'b0;
            hold_low--;
        end else begin
            out_ready = rand_ordy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        #1;
        if (out_ready) chk("in_ready_free", {63'd0, rdy0}, 64'd1);
        got = v && rdy0 && !rst;
        if (got) model_beat(x, y, clr);
    endtask

    task automatic send(input logic [7:0] x, input logic [7:0] y, input bit clr);
        bit got = 1'b0;
        int tries = 0;
        while (!got && tries < 100) begin
            cycle_drive(1'b1, x, y, clr, got);
            tries++;
        end
        if (!got) chk("send_timeout", 64'(tries), 64'd0);
    endtask

    task automatic idle(input int n);
        bit got;
        for (int i = 0; i < n; i++) cycle_drive(1'b0, 8'd0, 8'd0, 1'b0, got);
    endtask

    task automatic drain();
        int t = 0;
        while ((q0.size() != 0 || q1.size() != 0) && t < 200) begin
            idle(1);
            t++;
        end
        idle(2);
        chk("drain_left", 64'(q0.size() + q1.size()), 64'd0);
    endtask

    task automatic check_reset_state();
        chk("rst_out_valid0", {63'd0, ov0}, 64'd0);
        chk("rst_acc0", 64'(acc0), 64'd0);
        chk("rst_ovf0", {63'd0, of0}, 64'd0);
        chk("rst_in_ready0", {63'd0, rdy0}, 64'd1);
        chk("rst_out_valid1", {63'd0, ov1}, 64'd0);
        chk("rst_acc1", 64'(acc1), 64'd0);
        chk("rst_ovf1", {63'd0, of1}, 64'd0);
        chk("rst_in_ready1", {63'd0, rdy1}, 64'd1);
    endtask

    task automatic do_reset(input bit with_valid);
        @(posedge clk);
        #2;
        rst       = 1'b1;
        in_valid  = with_valid;
        a         = 8'd7;
        b         = 8'd9;
        acc_clr   = 1'b0;
        out_ready = 1'b1;
        q0.delete();
        q1.delete();
        for (int d = 0; d < 2; d++) begin
            m_acc[d] = 0;
            m_ovf[d] = 1'b0;
        end
        @(posedge clk);
        #2;
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check_reset_state();
    endtask

    task automatic mon(input int d, input logic ovld, input logic [63:0] av, input logic of, input logic rdy);
        exp_t e;
        int   sz;
        sz = (d == 0) ? q0.size() : q1.size();
        if (!ovld) return;
        if (sz == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out dut%0d: got out_valid=1 acc=%0d expected no pending beat", d, av);
            return;
        end
        e = (d == 0) ? q0[0] : q1[0];
        if (!out_ready) begin
            chk($sformatf("stall_in_ready%0d", d), {63'd0, rdy}, 64'd0);
            chk($sformatf("stall_acc%0d", d), av, 64'(e.acc));
        end else begin
            if (d == 0) void'(q0.pop_front());
            else        void'(q1.pop_front());
            chk($sformatf("acc%0d", d), av, 64'(e.acc));
            chk($sformatf("ovf%0d", d), {63'd0, of}, {63'd0, e.ovf});
            if (e.ff && free_flow) chk($sformatf("latency%0d", d), 64'(cyc - e.cyc), 64'd2);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            mon(0, ov0, 64'(acc0), of0, rdy0);
            mon(1, ov1, 64'(acc1), of1, rdy1);
        end
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        acc_clr   = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        for (int d = 0; d < 2; d++) begin
            m_acc[d] = 0;
            m_ovf[d] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        check_reset_state();

        // Directed products and overflow corner.
        send(8'd15, 8'd15, 1'b1);
        idle(4);
        send(8'd255, 8'd1, 1'b1);
        send(8'd3, 8'd5, 1'b0);
        idle(4);
        send(8'd255, 8'd255, 1'b1);
        send(8'd255, 8'd255, 1'b0);
        idle(4);
        send(8'd255, 8'd255, 1'b0);
        drain();

        // Back-to-back random beats.
        for (int i = 0; i < 100; i++)
            send(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), i == 0);
        drain();

        // Hold out_ready low while beats keep arriving.
        free_flow = 1'b0;
        send(8'd10, 8'd20, 1'b1);
        send(8'd11, 8'd21, 1'b0);
        hold_low = 6;
        for (int i = 0; i < 10; i++)
            send(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b0);
        drain();

        // Random traffic with random backpressure.
        rand_ordy = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 3) != 0)
                send(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), $urandom_range(0, 7) == 0);
            else
                idle(1);
        end
        rand_ordy = 1'b0;
        drain();

        // Reset with both stages full, then accumulate from zero.
        free_flow = 1'b1;
        send(8'd200, 8'd200, 1'b0);
        send(8'd201, 8'd202, 1'b0);
        send(8'd203, 8'd204, 1'b0);
        do_reset(1'b1);
        idle(4);
        send(8'd3, 8'd5, 1'b0);
        send(8'd15, 8'd15, 1'b0);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
